up_processor_set_pipelinemult1: RTL and testbench

UP_PROCESSOR_SET_PIPELINEMULT1 -- requirements
Module: up_processor_set_pipelinemult1

---
 rtl/up_processor_set_pipelinemult1.sv | 115 +++++++++++
 tb/tb_up_processor_set_pipelinemult1.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/up_processor_set_pipelinemult1.sv
// Weight/bias update datapath: new = sat(old - eta*act*delta), eta a power of two.
// Two register stages: registered product, then scale/subtract/saturate into the output register.
module up_processor_set_pipelinemult1 #(
  parameter int z        = 32,
  parameter int fi       = 16,
  parameter int width    = 10,
  parameter int int_bits = 2
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic [$clog2(width-int_bits+1)-1:0]       etapos,
  input  logic [width*z/fi-1:0]                     del_in_package,
  input  logic [width*z-1:0]                        wt_package,
  input  logic [width*z/fi-1:0]                     bias_package,
  input  logic [width*z-1:0]                        act_in_package,
  output logic [width*z-1:0]                        wt_UP_package,
  output logic [width*z/fi-1:0]                     bias_UP_package
);

  localparam int frac_bits = width - int_bits - 1;
  localparam int N         = z / fi;
  localparam int EW        = $clog2(frac_bits + 2);
  localparam int PW        = 2 * width;
  localparam int XW        = 2 * width + 1;

  localparam logic signed [XW-1:0] MAX_V = {{(XW-width+1){1'b0}}, {(width-1){1'b1}}};
  localparam logic signed [XW-1:0] MIN_V = ~MAX_V;

  function automatic logic [width-1:0] sat(input logic signed [XW-1:0] v);
    if (v > MAX_V)      return MAX_V[width-1:0];
    else if (v < MIN_V) return MIN_V[width-1:0];
    else                return v[width-1:0];
  endfunction

  logic [EW-1:0] eta_q;
  logic [7:0]    wsh;
  logic [7:0]    bsh;
  logic          eta_zero;

  always_ff @(posedge clk) begin
    if (reset) eta_q <= '0;
    else       eta_q <= etapos;
  end

  // Product already carries frac_bits extra fraction bits, hence the offset.
  assign wsh      = 8'(frac_bits) + 8'(eta_q) - 8'd1;
  assign bsh      = 8'(eta_q) - 8'd1;
  assign eta_zero = (eta_q == '0);

  genvar gi;
  generate
    for (gi = 0; gi < z; gi++) begin : g_wt
      logic signed [PW-1:0]    prod_d;
      logic signed [PW-1:0]    prod_q;
      logic        [width-1:0] wt_q;
      logic signed [PW-1:0]    scaled;
      logic signed [XW-1:0]    term;
      logic signed [XW-1:0]    diff;
      logic        [width-1:0] wt_up_d;
      logic        [width-1:0] wt_up_q;

      assign prod_d = $signed(act_in_package[width*gi +: width])
                    * $signed(del_in_package[width*(gi/fi) +: width]);

      always_ff @(posedge clk) begin
        if (reset) begin
          prod_q  <= '0;
          wt_q    <= '0;
          wt_up_q <= '0;
        end else begin
          prod_q  <= prod_d;
          wt_q    <= wt_package[width*gi +: width];
          wt_up_q <= wt_up_d;
        end
      end

      assign scaled  = prod_q >>> wsh;
      assign term    = eta_zero ? '0 : {scaled[PW-1], scaled};
      assign diff    = {{(XW-width){wt_q[width-1]}}, wt_q} - term;
      assign wt_up_d = sat(diff);

      assign wt_UP_package[width*gi +: width] = wt_up_q;
    end

    for (gi = 0; gi < N; gi++) begin : g_bias
      logic signed [width-1:0] del_q;
      logic        [width-1:0] bias_q;
      logic signed [width-1:0] scaled;
      logic signed [XW-1:0]    term;
      logic signed [XW-1:0]    diff;
      logic        [width-1:0] bias_up_d;
      logic        [width-1:0] bias_up_q;

      always_ff @(posedge clk) begin
        if (reset) begin
          del_q     <= '0;
          bias_q    <= '0;
          bias_up_q <= '0;
        end else begin
          del_q     <= del_in_package[width*gi +: width];
          bias_q    <= bias_package[width*gi +: width];
          bias_up_q <= bias_up_d;
        end
      end

      assign scaled    = del_q >>> bsh;
      assign term      = eta_zero ? '0 : {{(XW-width){scaled[width-1]}}, scaled};
      assign diff      = {{(XW-width){bias_q[width-1]}}, bias_q} - term;
      assign bias_up_d = sat(diff);

      assign bias_UP_package[width*gi +: width] = bias_up_q;
    end
  endgenerate

endmodule

// File: tb/tb_up_processor_set_pipelinemult1.sv
// Directed-vector bench for the weight/bias update pipeline at default parameters.
module tb_up_processor_set_pipelinemult1;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   etapos;
  logic [19:0]  del_in_package;
  logic [319:0] wt_package;
  logic [19:0]  bias_package;
  logic [319:0] act_in_package;
  logic [319:0] wt_UP_package;
  logic [19:0]  bias_UP_package;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  up_processor_set_pipelinemult1 dut (
    .clk             (clk),
    .reset           (reset),
    .etapos          (etapos),
    .del_in_package  (del_in_package),
    .wt_package      (wt_package),
    .bias_package    (bias_package),
    .act_in_package  (act_in_package),
    .wt_UP_package   (wt_UP_package),
    .bias_UP_package (bias_UP_package)
  );

  typedef struct {
    string        name;
    logic [3:0]   eta;
    logic [19:0]  del;
    logic [319:0] act;
    logic [319:0] wt;
    logic [19:0]  bias;
    logic [319:0] ewt;
    logic [19:0]  ebias;
  } vec_t;

  vec_t vecs[8];

  // n1 fills weights 16..31, n0 fills weights 0..15
  function automatic logic [319:0] rep(input logic [9:0] n1, input logic [9:0] n0);
    logic [319:0] r;
    for (int i = 0; i < 32; i++) r[10*i +: 10] = (i >= 16) ? n1 : n0;
    return r;
  endfunction

  function automatic logic [319:0] patt(input int seed);
    logic [319:0] r;
    for (int i = 0; i < 32; i++) r[10*i +: 10] = 10'((seed + 37 * i) % 1024);
    return r;
  endfunction

  function automatic logic [319:0] mix(input logic [319:0] hi, input logic [319:0] lo);
    return {hi[319:160], lo[159:0]};
  endfunction

  task automatic chk_w(input string name, input logic [319:0] got, input logic [319:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s wt_UP got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic chk_b(input string name, input logic [19:0] got, input logic [19:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s bias_UP got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    etapos         = v.eta;
    del_in_package = v.del;
    act_in_package = v.act;
    wt_package     = v.wt;
    bias_package   = v.bias;
  endtask

  vec_t va, vb;

  initial begin
    vecs[0] = '{"eta2_sat_pos", 4'd2, 20'h40180, rep(10'h080, 10'h200), '0, 20'h0,
                rep(10'h380, 10'h1FF), 20'he0340};
    vecs[1] = '{"eta1_neg_act", 4'd1, 20'h40180, rep(10'h380, 10'h000), '0, 20'h0,
                rep(10'h100, 10'h000), 20'hc0280};
    vecs[2] = '{"eta1_wt_bias", 4'd1, 20'h40180, rep(10'h380, 10'h000),
                mix(rep(10'h080, 10'h0), patt(11)), {10'h080, 10'h1FF},
                mix(rep(10'h100 + 10'h080, 10'h0), patt(11)), 20'he007f};
    vecs[3] = '{"eta0_pass", 4'd0, 20'h556AA, patt(5), patt(300), {10'h123, 10'h2F0},
                patt(300), {10'h123, 10'h2F0}};
    vecs[4] = '{"sat_neg", 4'd1, 20'h20080, rep(10'h080, 10'h080), rep(10'h200, 10'h200),
                {10'h200, 10'h200}, rep(10'h200, 10'h200), 20'h80200};
    vecs[5] = '{"floor_bias_sat", 4'd2, {10'h380, 10'h3FF}, rep(10'h080, 10'h001), '0,
                {10'h1FF, 10'h000}, rep(10'h040, 10'h001), 20'h7FC01};
    vecs[6] = '{"eta_max", 4'd8, 20'h7FDFF, rep(10'h1FF, 10'h1FF), '0, 20'h0,
                rep(10'h3F1, 10'h3F1), 20'hFF7FD};
    vecs[7] = '{"eta0_pass2", 4'd0, 20'hFFFFF, rep(10'h1FF, 10'h1FF), patt(777),
                {10'h200, 10'h1FF}, patt(777), {10'h200, 10'h1FF}};

    // reset with non-zero inputs present
    reset = 1'b1;
    drive(vecs[0]);
    repeat (4) @(negedge clk);
    chk_w("reset", wt_UP_package, '0);
    chk_b("reset", bias_UP_package, 20'h0);
    $display("txn reset: wt_UP=%h bias_UP=%h", wt_UP_package, bias_UP_package);
    reset = 1'b0;

    foreach (vecs[k]) begin
      drive(vecs[k]);
      repeat (2) @(negedge clk);
      chk_w(vecs[k].name, wt_UP_package, vecs[k].ewt);
      chk_b(vecs[k].name, bias_UP_package, vecs[k].ebias);
      $display("txn %s: eta=%0d bias_UP=%h", vecs[k].name, vecs[k].eta, bias_UP_package);
    end

    // latency: A held, then B applied; one edge later still A, two edges later B
    va = vecs[0];
    vb = vecs[1];
    drive(va);
    repeat (2) @(negedge clk);
    drive(vb);
    @(negedge clk);
    chk_w("latency_hold", wt_UP_package, va.ewt);
    chk_b("latency_hold", bias_UP_package, va.ebias);
    @(negedge clk);
    chk_w("latency_new", wt_UP_package, vb.ewt);
    chk_b("latency_new", bias_UP_package, vb.ebias);
    $display("txn latency: bias_UP=%h", bias_UP_package);

    // back-to-back streaming: one new vector per cycle
    drive(vecs[4]);
    @(negedge clk);
    drive(vecs[5]);
    @(negedge clk);
    drive(vecs[6]);
    chk_w("stream_a", wt_UP_package, vecs[4].ewt);
    @(negedge clk);
    chk_w("stream_b", wt_UP_package, vecs[5].ewt);
    chk_b("stream_b", bias_UP_package, vecs[5].ebias);
    @(negedge clk);
    chk_b("stream_c", bias_UP_package, vecs[6].ebias);
    $display("txn stream: bias_UP=%h", bias_UP_package);

    // mid-operation reset discards in-flight data
    drive(vecs[0]);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_w("midreset", wt_UP_package, '0);
    chk_b("midreset", bias_UP_package, 20'h0);
    reset = 1'b0;
    drive(vecs[1]);
    @(negedge clk);
    chk_b("post_reset_1", bias_UP_package, 20'h0);
    @(negedge clk);
    chk_w("post_reset_2", wt_UP_package, vecs[1].ewt);
    chk_b("post_reset_2", bias_UP_package, vecs[1].ebias);
    $display("txn midreset: bias_UP=%h", bias_UP_package);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
